nes_pad_responder: RTL and testbench
====================================

// Module: nes_pad_responder
// PURPOSE
//  Controller-side end of the NES joypad serial link: emulates a standard 4021-based pad.
//  Captures button state on joy_strobe and shifts it out on joy_data, one bit per joy_clock.
//  Sits at the board edge, wired to a second console or to the NES core's joy_strobe/joy_clock.
//  Button source is a clock-domain bus (debounced GPIO or UART bridge); adds turbo and read stats.
// PARAMETERS
//  SYNC_STAGES  2   flops in each input synchroniser on joy_strobe/joy_clock (>=2)
//  FILT_CYCLES  3   consecutive cycles a synced input must differ before its filtered level flips (>=1)
//  TURBO_DIV    4   latches per turbo phase toggle (>=1)
//  FILL_BIT     1   pressed-domain value shifted in after the 8 real bits (1 = wire 0, as official pad)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  buttons_in    in   8   pressed=1; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right; clock domain
//  turbo_en      in   2   [0] turbo on A, [1] turbo on B
//  joy_strobe    in   1   async latch line from host
//  joy_clock     in   1   async shift clock from host
//  joy_data      out  1   serial data, active-low on wire (0 = pressed), registered
//  latch_pulse   out  1   1-cycle pulse on each completed latch (filtered strobe falling edge)
//  read_count    out  16  number of latches since reset, wraps 0xFFFF->0
//  bits_pending  out  4   real button bits not yet shifted out (8..0)
//  overread      out  1   sticky: joy_clock rising edge seen with bits_pending==0; cleared on next latch
// BEHAVIOUR
//  Reset: state IDLE; shreg=0; joy_data=1; latch_pulse=0; read_count=0; bits_pending=0; overread=0;
//   turbo counter=0, turbo phase=1; filtered strobe/clock=0; filter counters=0.
//  Input path: each line -> SYNC_STAGES flops -> filter (counter resets when synced==filtered;
//   filtered flips when counter reaches FILT_CYCLES). Edge detect on filtered levels only.
//  Latency: stable pin change -> filtered edge after SYNC_STAGES+FILT_CYCLES cycles; joy_data
//   updates one cycle later (6 cycles at defaults). Pulses shorter than FILT_CYCLES are ignored.
//  Effective buttons: eff=buttons_in; eff[0]&=~turbo_en[0]|phase; eff[1]&=~turbo_en[1]|phase.
//  FSM (filtered strobe = S, filtered clock rising edge = CR):
//   IDLE : S=1 -> LATCH.  CR ignored; joy_data=1.
//   LATCH: every cycle shreg<=eff, bits_pending<=8, joy_data<=~eff[0]. CR ignored.
//          S falling -> SHIFT; latch_pulse=1 that cycle; read_count+=1; overread<=0; turbo step.
//   SHIFT: on CR: shreg<={FILL_BIT,shreg[7:1]}; bits_pending-=1; joy_data<=~new shreg[0].
//          bits_pending reaching 0 -> DONE.
//   DONE : CR -> shift FILL_BIT in as in SHIFT, bits_pending stays 0, overread<=1.
//   Any state: S rising -> LATCH next cycle (aborts partial read; no count, no pulse).
//  Simultaneous S rising and CR in one cycle: latch wins, shift discarded.
//  Turbo step: counter+=1; when counter==TURBO_DIV-1, counter<=0 and phase toggles.
//   Phase 1 on first read after reset (turbo button reads pressed).
//  buttons_in changes during SHIFT/DONE have no effect until next LATCH.
//  reset asserted mid-read: all state to reset values on that edge; joy_data=1 next cycle.
// TESTING
//  1. buttons_in=8'h81, strobe pulse, 8 clocks -> wire bits 0,1,1,1,1,1,1,0; bits_pending 8..0; latch_pulse once.
//  2. After test 1, 2 extra clocks -> joy_data=0 (FILL_BIT=1) both, overread=1; next latch clears overread.
//  3. 2-cycle glitch on joy_clock in SHIFT -> no shift, bits_pending unchanged; 3-cycle stable pulse -> shifts.
//  4. Strobe re-asserted after 3 shifts -> LATCH, bits_pending=8, joy_data=~buttons_in[0], read_count +1 only on fall.
//  5. turbo_en=2'b01, A held, 8 latches -> A reads pressed,pressed,pressed,pressed, then released x4 (TURBO_DIV=4).
//  6. read_count preset by 65535 latches -> next latch wraps to 0; reset mid-shift -> joy_data=1, outputs zero.

Source files
------------

// File: rtl/nes_pad_responder.sv
// Device end of the NES joypad link: emulates a 4021-based pad with turbo on A/B and read statistics.
// joy_strobe/joy_clock are synchronised and glitch-filtered before any edge is acted on.
module nes_pad_responder #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 3,
  parameter int   TURBO_DIV   = 4,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  buttons_in,
  input  logic [1:0]  turbo_en,
  input  logic        joy_strobe,
  input  logic        joy_clock,
  output logic        joy_data,
  output logic        latch_pulse,
  output logic [15:0] read_count,
  output logic [3:0]  bits_pending,
  output logic        overread
);

  localparam int FCW = $clog2(FILT_CYCLES + 1);
  localparam int TCW = $clog2(TURBO_DIV + 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t                 state_q, state_nx;
  logic [1:0]             pins;
  logic [SYNC_STAGES-1:0] sync_p0 [2];
  logic [FCW-1:0]         fcnt_q  [2];
  logic [1:0]             filt_p1, filt_p2;
  logic                   s_lvl, s_rise, s_fall, c_rise;
  logic [7:0]             shreg, shifted, eff;
  logic [TCW-1:0]         tcnt;
  logic                   phase;
  logic                   do_load, do_shift, do_count;

  // Index 0 carries the strobe line, index 1 the shift clock.
  assign pins = {joy_clock, joy_strobe};

  // Stage p0/p1: synchronise, then only flip the filtered level after FILT_CYCLES disagreeing cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i] <= '0;
        fcnt_q[i]  <= '0;
      end
      filt_p1 <= '0;
      filt_p2 <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_p0[i] <= {sync_p0[i][SYNC_STAGES-2:0], pins[i]};
        if (sync_p0[i][SYNC_STAGES-1] == filt_p1[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_CYCLES - 1)) begin
          fcnt_q[i]  <= '0;
          filt_p1[i] <= ~filt_p1[i];
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
      filt_p2 <= filt_p1;
    end
  end

  // Stage p2: edge detection on filtered levels feeds the pad FSM
  assign s_lvl   = filt_p1[0];
  assign s_rise  = filt_p1[0] & ~filt_p2[0];
  assign s_fall  = ~filt_p1[0] & filt_p2[0];
  assign c_rise  = filt_p1[1] & ~filt_p2[1];
  assign shifted = {FILL_BIT, shreg[7:1]};

  always_comb begin
    eff    = buttons_in;
    eff[0] = buttons_in[0] & (~turbo_en[0] | phase);
    eff[1] = buttons_in[1] & (~turbo_en[1] | phase);
  end

  // A strobe rising edge overrides everything, including a coincident shift clock.
  always_comb begin
    state_nx = state_q;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_count = 1'b0;
    if (s_rise) begin
      state_nx = LATCH;
      do_load  = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (s_lvl) begin
          state_nx = LATCH;
          do_load  = 1'b1;
        end
        LATCH: begin
          do_load = 1'b1;
          if (s_fall) begin
            state_nx = SHIFT;
            do_count = 1'b1;
          end
        end
        SHIFT: if (c_rise) begin
          do_shift = 1'b1;
          if (bits_pending == 4'd1) state_nx = DONE;
        end
        DONE: if (c_rise) do_shift = 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg        <= '0;
      joy_data     <= 1'b1;
      latch_pulse  <= 1'b0;
      read_count   <= '0;
      bits_pending <= '0;
      overread     <= 1'b0;
      tcnt         <= '0;
      phase        <= 1'b1;
    end else begin
      state_q     <= state_nx;
      latch_pulse <= do_count;
      if (do_load) begin
        shreg        <= eff;
        bits_pending <= 4'd8;
        joy_data     <= ~eff[0];
      end else if (do_shift) begin
        shreg    <= shifted;
        joy_data <= ~shifted[0];
        if (state_q == SHIFT) bits_pending <= bits_pending - 4'd1;
        else                  overread     <= 1'b1;
      end
      if (do_count) begin
        read_count <= read_count + 16'd1;
        overread   <= 1'b0;
        if (tcnt == TCW'(TURBO_DIV - 1)) begin
          tcnt  <= '0;
          phase <= ~phase;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder at default parameters; expected values are hand-derived.
module tb_nes_pad_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  buttons_in;
  logic [1:0]  turbo_en;
  logic        joy_strobe;
  logic        joy_clock;
  logic        joy_data;
  logic        latch_pulse;
  logic [15:0] read_count;
  logic [3:0]  bits_pending;
  logic        overread;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  nes_pad_responder dut (
    .clock        (clock),
    .reset        (reset),
    .buttons_in   (buttons_in),
    .turbo_en     (turbo_en),
    .joy_strobe   (joy_strobe),
    .joy_clock    (joy_clock),
    .joy_data     (joy_data),
    .latch_pulse  (latch_pulse),
    .read_count   (read_count),
    .bits_pending (bits_pending),
    .overread     (overread)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (latch_pulse === 1'b1) pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe_pulse();
    joy_strobe = 1'b1;
    tick(8);
    joy_strobe = 1'b0;
    tick(8);
  endtask

  task automatic clk_pulse(input int hi);
    joy_clock = 1'b1;
    tick(hi);
    joy_clock = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [7:0] wire_exp;
    int base;
    wire_exp   = 8'b0111_1110;  // bit i = expected wire level after i clocks for buttons 0x81
    reset      = 1'b1;
    buttons_in = 8'h00;
    turbo_en   = 2'b00;
    joy_strobe = 1'b0;
    joy_clock  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_data", joy_data, 1);
    chk("rst_pulse", latch_pulse, 0);
    chk("rst_count", read_count, 0);
    chk("rst_pending", bits_pending, 0);
    chk("rst_overread", overread, 0);

    // Shift clocks in IDLE are ignored
    clk_pulse(8);
    chk("idle_clk_data", joy_data, 1);
    chk("idle_clk_pending", bits_pending, 0);

    // Test 1: 0x81 read out over 8 clocks
    buttons_in = 8'h81;
    strobe_pulse();
    chk("t1_pulses", pulses, 1);
    chk("t1_count", read_count, 1);
    chk("t1_pending0", bits_pending, 8);
    chk("t1_bit0", joy_data, wire_exp[0]);
    buttons_in = 8'h7E;  // ignored until the next latch
    for (int i = 1; i < 8; i++) begin
      clk_pulse(8);
      chk($sformatf("t1_bit%0d", i), joy_data, wire_exp[i]);
      chk($sformatf("t1_pending%0d", i), bits_pending, 8 - i);
    end
    clk_pulse(8);
    chk("t1_fill", joy_data, 0);
    chk("t1_pending8", bits_pending, 0);
    chk("t1_no_overread", overread, 0);
    chk("t1_pulses_end", pulses, 1);

    // Test 2: over-read shifts fill bits and sets sticky flag
    for (int i = 0; i < 2; i++) begin
      clk_pulse(8);
      chk($sformatf("t2_fill%0d", i), joy_data, 0);
      chk($sformatf("t2_overread%0d", i), overread, 1);
      chk($sformatf("t2_pending%0d", i), bits_pending, 0);
    end
    buttons_in = 8'h81;
    strobe_pulse();
    chk("t2_overread_clr", overread, 0);
    chk("t2_count", read_count, 2);

    // Test 3: short glitch on joy_clock ignored, 3-cycle pulse accepted
    clk_pulse(2);
    chk("t3_glitch_pending", bits_pending, 8);
    chk("t3_glitch_data", joy_data, 0);
    clk_pulse(3);
    chk("t3_pulse_pending", bits_pending, 7);
    chk("t3_pulse_data", joy_data, 1);

    // Test 4: re-strobe mid-read aborts and reloads
    clk_pulse(8);
    clk_pulse(8);
    chk("t4_pending_pre", bits_pending, 5);
    buttons_in = 8'h02;
    joy_strobe = 1'b1;
    tick(8);
    chk("t4_pending", bits_pending, 8);
    chk("t4_data", joy_data, 1);
    chk("t4_count_hold", read_count, 2);
    chk("t4_pulses_hold", pulses, 2);
    joy_strobe = 1'b0;
    tick(8);
    chk("t4_count", read_count, 3);
    chk("t4_pulses", pulses, 3);

    // Test 5: turbo on A, fresh from reset
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    turbo_en   = 2'b01;
    buttons_in = 8'h03;
    base       = pulses;
    for (int k = 0; k < 8; k++) begin
      strobe_pulse();
      chk($sformatf("t5_turbo%0d", k), joy_data, (k < 4) ? 0 : 1);
    end
    chk("t5_pulses", pulses - base, 8);
    chk("t5_count", read_count, 8);
    clk_pulse(8);
    chk("t5_b_unaffected", joy_data, 0);

    // Test 6: counter wrap, then reset mid-shift
    force dut.read_count = 16'hFFFE;
    tick(1);
    release dut.read_count;
    tick(1);
    strobe_pulse();
    chk("t6_count_ffff", read_count, 16'hFFFF);
    strobe_pulse();
    chk("t6_count_wrap", read_count, 0);
    clk_pulse(8);
    chk("t6_pending_pre", bits_pending, 7);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_data", joy_data, 1);
    chk("t6_rst_pending", bits_pending, 0);
    chk("t6_rst_count", read_count, 0);
    chk("t6_rst_overread", overread, 0);
    chk("t6_rst_pulse", latch_pulse, 0);
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
